// File: rtl/exec_complete_arbiter_if.sv
// rtl/exec_complete_arbiter_if.sv - completion-side bundle between execute units, arbiter and CDB
//
// Signals (names seen from the arbiter):
//   unitValid_i    [NUM_UNITS]            unit k holds a finished result
//   unitVal_i      [NUM_UNITS*64]         result values, unit k at [64k+63:64k]
//   unitCommands_i [NUM_UNITS*10]         commands, packed the same way
//   unitTag_i      [NUM_UNITS*ROBsizeLog] ROB tags, packed the same way
//   unitFlags_i    [NUM_UNITS*4]          flags, packed the same way
//   canGo_o        [NUM_UNITS]            one-hot grant back to the units
//   robReady_i                            CDB consumer accepts the entry this cycle
//   cdbValid_o, cdbVal_o, cdbCommands_o, cdbTag_o, cdbFlags_o, cdbUnit_o  registered CDB entry
// Modports: slave = arbiter side, master = units/ROB environment side.
interface exec_complete_arbiter_if #(
    parameter int NUM_UNITS  = 4,
    parameter int ROBsize    = 16,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) ();
    logic [NUM_UNITS-1:0]            unitValid_i;
    logic [NUM_UNITS*64-1:0]         unitVal_i;
    logic [NUM_UNITS*10-1:0]         unitCommands_i;
    logic [NUM_UNITS*ROBsizeLog-1:0] unitTag_i;
    logic [NUM_UNITS*4-1:0]          unitFlags_i;
    logic [NUM_UNITS-1:0]            canGo_o;
    logic                            robReady_i;
    logic                            cdbValid_o;
    logic [63:0]                     cdbVal_o;
    logic [9:0]                      cdbCommands_o;
    logic [ROBsizeLog-1:0]           cdbTag_o;
    logic [3:0]                      cdbFlags_o;
    logic [$clog2(NUM_UNITS)-1:0]    cdbUnit_o;

    modport slave (
        input  unitValid_i, unitVal_i, unitCommands_i, unitTag_i, unitFlags_i, robReady_i,
        output canGo_o, cdbValid_o, cdbVal_o, cdbCommands_o, cdbTag_o, cdbFlags_o, cdbUnit_o
    );

    modport master (
        output unitValid_i, unitVal_i, unitCommands_i, unitTag_i, unitFlags_i, robReady_i,
        input  canGo_o, cdbValid_o, cdbVal_o, cdbCommands_o, cdbTag_o, cdbFlags_o, cdbUnit_o
    );
endinterface

// File: rtl/exec_complete_arbiter.sv
// rtl/exec_complete_arbiter.sv - execute-stage completion arbiter driving the common data bus
//
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset
//   bus      exec_complete_arbiter_if.slave (unit results in, canGo out, registered CDB out)
// Build option: EXEC_ARB_FIXED_PRIO_EN selects fixed priority (lowest unit index wins)
// instead of round-robin; the round-robin pointer is then not built.
module exec_complete_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int ROBsize    = 16,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    exec_complete_arbiter_if.slave bus
);
    localparam int UW = $clog2(NUM_UNITS);

    logic                  w_load_en;
    logic                  w_any;
    logic                  w_grant;
    logic [UW-1:0]         w_base;
    logic [UW-1:0]         w_win;
    logic [UW:0]           w_idx;

    logic                  r_cdb_valid;
    logic [63:0]           r_cdb_val;
    logic [9:0]            r_cdb_cmd;
    logic [ROBsizeLog-1:0] r_cdb_tag;
    logic [3:0]            r_cdb_flags;
    logic [UW-1:0]         r_cdb_unit;

    // The output register can take a new entry when empty or being drained this cycle.
    assign w_load_en = ~r_cdb_valid | bus.robReady_i;

    // Search starting at w_base, wrapping; the extra index bit keeps the wrap free of overflow.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_idx = {1'b0, w_base} + (UW + 1)'(i);
            if (w_idx >= (UW + 1)'(NUM_UNITS)) begin
                w_idx = w_idx - (UW + 1)'(NUM_UNITS);
            end
            if (!w_any && bus.unitValid_i[w_idx[UW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[UW-1:0];
            end
        end
    end

    assign w_grant = w_any & w_load_en & ~reset_i;

    always_comb begin
        bus.canGo_o = '0;
        if (w_grant) begin
            bus.canGo_o[w_win] = 1'b1;
        end
    end

`ifdef EXEC_ARB_FIXED_PRIO_EN
    assign w_base = '0;
`else
    logic [UW-1:0] r_rr_ptr;

    // Pointer moves just past the winner, so only grants advance it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (w_win == UW'(NUM_UNITS - 1)) ? '0 : w_win + 1'b1;
        end
    end

    assign w_base = r_rr_ptr;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cdb_valid <= 1'b0;
            r_cdb_val   <= '0;
            r_cdb_cmd   <= '0;
            r_cdb_tag   <= '0;
            r_cdb_flags <= '0;
            r_cdb_unit  <= '0;
        end else if (w_grant) begin
            r_cdb_valid <= 1'b1;
            r_cdb_val   <= bus.unitVal_i[64*w_win +: 64];
            r_cdb_cmd   <= bus.unitCommands_i[10*w_win +: 10];
            r_cdb_tag   <= bus.unitTag_i[ROBsizeLog*w_win +: ROBsizeLog];
            r_cdb_flags <= bus.unitFlags_i[4*w_win +: 4];
            r_cdb_unit  <= w_win;
        end else if (bus.robReady_i) begin
            // Drained with nothing to refill: payload is left as-is.
            r_cdb_valid <= 1'b0;
        end
    end

    assign bus.cdbValid_o    = r_cdb_valid;
    assign bus.cdbVal_o      = r_cdb_val;
    assign bus.cdbCommands_o = r_cdb_cmd;
    assign bus.cdbTag_o      = r_cdb_tag;
    assign bus.cdbFlags_o    = r_cdb_flags;
    assign bus.cdbUnit_o     = r_cdb_unit;

    // A waiting unit must keep valid and payload steady until it is granted.
    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_proto
        a_hold: assert property (@(posedge clk_i) disable iff (reset_i)
            (bus.unitValid_i[k] && !bus.canGo_o[k]) |=>
            (bus.unitValid_i[k]
             && $stable(bus.unitVal_i[64*k +: 64])
             && $stable(bus.unitCommands_i[10*k +: 10])
             && $stable(bus.unitTag_i[ROBsizeLog*k +: ROBsizeLog])
             && $stable(bus.unitFlags_i[4*k +: 4])));
    end
endmodule

// File: tb/tb_exec_complete_arbiter.sv
// tb/tb_exec_complete_arbiter.sv - self-checking bench for exec_complete_arbiter
module tb_exec_complete_arbiter;
    localparam int N  = 4;
    localparam int RS = 16;
    localparam int TW = $clog2(RS + 1);

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    exec_complete_arbiter_if #(.NUM_UNITS(N), .ROBsize(RS)) ifc ();
    exec_complete_arbiter #(.NUM_UNITS(N), .ROBsize(RS)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (ifc)
    );

    int errors = 0;
    int checks = 0;

    // Unit-side stimulus state
    logic          u_v   [N];
    logic [63:0]   u_val [N];
    logic [9:0]    u_cmd [N];
    logic [TW-1:0] u_tag [N];
    logic [3:0]    u_fl  [N];
    logic          rob;

    // Reference CDB contents
    logic          m_v;
    logic [63:0]   m_val;
    logic [9:0]    m_cmd;
    logic [TW-1:0] m_tag;
    logic [3:0]    m_fl;
    logic [1:0]    m_unit;
    int            m_rr;

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            ifc.unitValid_i[k]            = u_v[k];
            ifc.unitVal_i[64*k +: 64]     = u_val[k];
            ifc.unitCommands_i[10*k +: 10] = u_cmd[k];
            ifc.unitTag_i[TW*k +: TW]     = u_tag[k];
            ifc.unitFlags_i[4*k +: 4]     = u_fl[k];
        end
        ifc.robReady_i = rob;
        #1;
    endtask

    // Winner by the arbitration rule: nothing in reset or when the CDB is full and stalled,
    // otherwise the first valid unit searching from the pointer with wrap.
    function automatic int exp_grant();
        int base;
        if (reset_i) return -1;
        if (m_v && !rob) return -1;
`ifdef EXEC_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = m_rr;
`endif
        for (int i = 0; i < N; i++) begin
            if (u_v[(base + i) % N]) return (base + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic set_unit(int k, logic [63:0] v, logic [TW-1:0] t);
        u_v[k]   = 1'b1;
        u_val[k] = v;
        u_tag[k] = t;
        u_cmd[k] = 10'(v + 3);
        u_fl[k]  = 4'(k + 1);
    endtask

    // One clock; the reference follows and a granted unit drops its valid.
    task automatic step();
        int g;
        g = exp_grant();
        @(posedge clk);
        if (reset_i) begin
            m_v = 1'b0; m_val = '0; m_cmd = '0; m_tag = '0; m_fl = '0; m_unit = '0; m_rr = 0;
        end else if (g >= 0) begin
            m_v = 1'b1; m_val = u_val[g]; m_cmd = u_cmd[g]; m_tag = u_tag[g]; m_fl = u_fl[g];
            m_unit = 2'(g);
            m_rr = (g + 1) % N;
            u_v[g] = 1'b0;
        end else if (rob) begin
            m_v = 1'b0;
        end
        #1;
        apply();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        apply();
        step();
        for (int k = 0; k < N; k++) u_v[k] = 1'b0;
        rob = 1'b0;
        apply();
        step();
        reset_i = 1'b0;
        apply();
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) set_unit(k, 64'(k), TW'(k));
        rob = 1'b1;
        reset_i = 1'b1;
        apply();
        checks++;
        if (ifc.canGo_o !== 4'b0000) begin
            errors++; $display("FAIL reset_cango got %b exp 0000", ifc.canGo_o);
        end
        step();
        checks++;
        if (ifc.cdbValid_o !== 1'b0 || ifc.cdbVal_o !== 64'd0 || ifc.cdbUnit_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_cdb got v=%b val=%h unit=%0d exp 0/0/0",
                     ifc.cdbValid_o, ifc.cdbVal_o, ifc.cdbUnit_o);
        end
        do_reset();
    endtask

    task automatic test_single_unit();
        logic [N-1:0] exp_next;
        do_reset();
        set_unit(2, 64'h1234, TW'(5));
        rob = 1'b1;
        apply();
        checks++;
        if (ifc.canGo_o !== 4'b0100) begin
            errors++; $display("FAIL single_cango got %b exp 0100", ifc.canGo_o);
        end
        step();
        checks++;
        if (ifc.cdbValid_o !== 1'b1 || ifc.cdbTag_o !== TW'(5) || ifc.cdbVal_o !== 64'h1234
            || ifc.cdbUnit_o !== 2'd2) begin
            errors++;
            $display("FAIL single_cdb got v=%b tag=%0d val=%h unit=%0d exp 1/5/1234/2",
                     ifc.cdbValid_o, ifc.cdbTag_o, ifc.cdbVal_o, ifc.cdbUnit_o);
        end
        set_unit(0, 64'hA0, TW'(1));
        set_unit(3, 64'hA3, TW'(2));
        apply();
`ifdef EXEC_ARB_FIXED_PRIO_EN
        exp_next = 4'b0001;
`else
        exp_next = 4'b1000;
`endif
        checks++;
        if (ifc.canGo_o !== exp_next) begin
            errors++; $display("FAIL single_ptr got %b exp %b", ifc.canGo_o, exp_next);
        end
        step();
        step();
    endtask

    task automatic test_round_robin();
        int seq [5];
`ifdef EXEC_ARB_FIXED_PRIO_EN
        seq = '{0, 0, 0, 0, 0};
`else
        seq = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        for (int k = 0; k < N; k++) set_unit(k, 64'(16 + k), TW'(k));
        rob = 1'b1;
        apply();
        for (int c = 0; c < 5; c++) begin
            logic [63:0] want_val;
            want_val = u_val[seq[c]];
            checks++;
            if (ifc.canGo_o !== onehot(seq[c])) begin
                errors++; $display("FAIL rr_cango[%0d] got %b exp %b", c, ifc.canGo_o, onehot(seq[c]));
            end
            step();
            checks++;
            if (ifc.cdbValid_o !== 1'b1 || ifc.cdbUnit_o !== 2'(seq[c]) || ifc.cdbVal_o !== want_val) begin
                errors++;
                $display("FAIL rr_cdb[%0d] got v=%b unit=%0d val=%h exp 1/%0d/%h",
                         c, ifc.cdbValid_o, ifc.cdbUnit_o, ifc.cdbVal_o, seq[c], want_val);
            end
            set_unit(seq[c], 64'(100 + c), TW'(c));
            apply();
        end
    endtask

    task automatic test_backpressure_and_drain();
        logic [N-1:0] exp_next;
        do_reset();
        set_unit(0, 64'hAAAA, TW'(7));
        rob = 1'b1;
        apply();
        step();
        rob = 1'b0;
        set_unit(1, 64'hBBBB, TW'(9));
        apply();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (ifc.canGo_o !== 4'b0000) begin
                errors++; $display("FAIL bp_cango[%0d] got %b exp 0000", c, ifc.canGo_o);
            end
            step();
            checks++;
            if (ifc.cdbValid_o !== 1'b1 || ifc.cdbVal_o !== 64'hAAAA || ifc.cdbTag_o !== TW'(7)
                || ifc.cdbUnit_o !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b val=%h tag=%0d unit=%0d exp 1/aaaa/7/0",
                         c, ifc.cdbValid_o, ifc.cdbVal_o, ifc.cdbTag_o, ifc.cdbUnit_o);
            end
        end
        rob = 1'b1;
        apply();
        checks++;
        if (ifc.canGo_o !== 4'b0010) begin
            errors++; $display("FAIL bp_release got %b exp 0010", ifc.canGo_o);
        end
        step();
        checks++;
        if (ifc.cdbValid_o !== 1'b1 || ifc.cdbVal_o !== 64'hBBBB || ifc.cdbUnit_o !== 2'd1) begin
            errors++;
            $display("FAIL bp_new got v=%b val=%h unit=%0d exp 1/bbbb/1",
                     ifc.cdbValid_o, ifc.cdbVal_o, ifc.cdbUnit_o);
        end
        // Drain with nothing waiting: entry empties, data and pointer untouched.
        checks++;
        if (ifc.canGo_o !== 4'b0000) begin
            errors++; $display("FAIL drain_cango got %b exp 0000", ifc.canGo_o);
        end
        step();
        checks++;
        if (ifc.cdbValid_o !== 1'b0 || ifc.cdbVal_o !== 64'hBBBB) begin
            errors++;
            $display("FAIL drain_cdb got v=%b val=%h exp 0/bbbb", ifc.cdbValid_o, ifc.cdbVal_o);
        end
        step();
        for (int k = 0; k < N; k++) set_unit(k, 64'(k), TW'(k));
        apply();
`ifdef EXEC_ARB_FIXED_PRIO_EN
        exp_next = 4'b0001;
`else
        exp_next = 4'b0100;
`endif
        checks++;
        if (ifc.canGo_o !== exp_next) begin
            errors++; $display("FAIL drain_ptr got %b exp %b", ifc.canGo_o, exp_next);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_unit(2, 64'h22, TW'(2));
        rob = 1'b1;
        apply();
        step();
        step();
        set_unit(0, 64'h50, TW'(3));
        set_unit(1, 64'h51, TW'(4));
        apply();
        checks++;
        if (ifc.canGo_o !== 4'b0001) begin
            errors++; $display("FAIL wrap_first got %b exp 0001", ifc.canGo_o);
        end
        step();
        checks++;
        if (ifc.canGo_o !== 4'b0010) begin
            errors++; $display("FAIL wrap_second got %b exp 0010", ifc.canGo_o);
        end
        step();
        checks++;
        if (ifc.cdbUnit_o !== 2'd1 || ifc.cdbVal_o !== 64'h51) begin
            errors++;
            $display("FAIL wrap_cdb got unit=%0d val=%h exp 1/51", ifc.cdbUnit_o, ifc.cdbVal_o);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_unit(0, 64'h77, TW'(6));
        rob = 1'b1;
        apply();
        step();
        rob = 1'b0;
        set_unit(3, 64'h88, TW'(8));
        reset_i = 1'b1;
        apply();
        checks++;
        if (ifc.canGo_o !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_cango got %b exp 0000", ifc.canGo_o);
        end
        step();
        checks++;
        if (ifc.cdbValid_o !== 1'b0 || ifc.cdbVal_o !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset_cdb got v=%b val=%h exp 0/0", ifc.cdbValid_o, ifc.cdbVal_o);
        end
        reset_i = 1'b0;
        rob = 1'b1;
        set_unit(0, 64'h99, TW'(1));
        apply();
        checks++;
        if (ifc.canGo_o !== 4'b0001) begin
            errors++; $display("FAIL mid_reset_ptr got %b exp 0001", ifc.canGo_o);
        end
        step();
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int g;
            for (int k = 0; k < N; k++) begin
                if (!u_v[k] && $urandom_range(1, 0) == 1) begin
                    u_v[k]   = 1'b1;
                    u_val[k] = {$urandom, $urandom};
                    u_cmd[k] = 10'($urandom);
                    u_tag[k] = TW'($urandom);
                    u_fl[k]  = 4'($urandom);
                end
            end
            rob = ($urandom_range(3, 0) != 0);
            apply();
            g = exp_grant();
            checks++;
            if (ifc.canGo_o !== onehot(g)) begin
                errors++; $display("FAIL rand_cango[%0d] got %b exp %b", c, ifc.canGo_o, onehot(g));
            end
            step();
            checks++;
            if (ifc.cdbValid_o !== m_v) begin
                errors++; $display("FAIL rand_valid[%0d] got %b exp %b", c, ifc.cdbValid_o, m_v);
            end else if (m_v) begin
                checks++;
                if (ifc.cdbVal_o !== m_val || ifc.cdbTag_o !== m_tag || ifc.cdbUnit_o !== m_unit
                    || ifc.cdbCommands_o !== m_cmd || ifc.cdbFlags_o !== m_fl) begin
                    errors++;
                    $display("FAIL rand_cdb[%0d] got val=%h tag=%0d unit=%0d cmd=%h fl=%h exp %h/%0d/%0d/%h/%h",
                             c, ifc.cdbVal_o, ifc.cdbTag_o, ifc.cdbUnit_o, ifc.cdbCommands_o,
                             ifc.cdbFlags_o, m_val, m_tag, m_unit, m_cmd, m_fl);
                end
            end
        end
    endtask

    initial begin
        reset_i = 1'b1;
        rob = 1'b0;
        for (int k = 0; k < N; k++) begin
            u_v[k] = 1'b0; u_val[k] = '0; u_cmd[k] = '0; u_tag[k] = '0; u_fl[k] = '0;
        end
        m_v = 1'b0; m_val = '0; m_cmd = '0; m_tag = '0; m_fl = '0; m_unit = '0; m_rr = 0;
        apply();
        step();
        test_reset();
        test_single_unit();
        test_round_robin();
        test_backpressure_and_drain();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
